// File: rtl/sgpr_copy_ctrl.sv
// -----------------------------------------------------------------------------
// sgpr_copy_ctrl
//
// Copies architectural registers FIRST_REG..LAST_REG from a source register
// file into the sgpr write port, one register per cycle. An optional second
// pass reads every register back through sgpr read port B, compares it with
// the source, and records the first mismatching address. This is used to move
// state onto a spare core during recovery.
//
// Ports
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   start_i         : start a sequence (honoured only while idle)
//   verify_en_i     : captured with start_i; 1 adds the readback/compare pass
//   abort_i         : end the current sequence at the next edge (no done_o)
//   busy_o          : high while copying or verifying
//   done_o          : one-cycle pulse when a sequence completes normally
//   error_o         : sticky mismatch flag, cleared by an accepted start
//   err_addr_o      : address of the first mismatch
//   src_raddr_o     : source register file read address (combinational read)
//   src_rdata_i     : source register file read data
//   dst_waddr_o     : sgpr write address  (waddr_a_i)
//   dst_wdata_o     : sgpr write data     (wdata_a_i)
//   dst_we_o        : sgpr write enable   (we_a_i)
//   dst_raddr_o     : sgpr read address   (raddr_b_i)
//   dst_rdata_i     : sgpr read data      (rdata_b_o, combinational read)
// -----------------------------------------------------------------------------
module sgpr_copy_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  verify_en_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [ADDR_WIDTH-1:0] src_raddr_o,
  input  logic [DATA_WIDTH-1:0] src_rdata_i,
  output logic [ADDR_WIDTH-1:0] dst_waddr_o,
  output logic [DATA_WIDTH-1:0] dst_wdata_o,
  output logic                  dst_we_o,
  output logic [ADDR_WIDTH-1:0] dst_raddr_o,
  input  logic [DATA_WIDTH-1:0] dst_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COPY   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_A = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_REG);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    verify_q, verify_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    last_reg;
  logic                    mismatch;

  assign last_reg = (cnt_q == LAST_A);
  assign mismatch = (src_rdata_i != dst_rdata_i);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    verify_d   = verify_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;

    case (state_q)
      S_IDLE: begin
        // abort_i wins over start_i so a simultaneous pair leaves us idle
        if (start_i && !abort_i) begin
          state_d    = S_COPY;
          cnt_d      = FIRST_A;
          verify_d   = verify_en_i;
          error_d    = 1'b0;
          err_addr_d = '0;
        end
      end

      S_COPY: begin
        if (abort_i) begin
          // the write presented this cycle still lands at this edge
          state_d = S_IDLE;
          cnt_d   = FIRST_A;
        end else if (last_reg) begin
          state_d = verify_q ? S_VERIFY : S_DONE;
          cnt_d   = FIRST_A;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end

      S_VERIFY: begin
        // only the first mismatch is recorded; the pass keeps running
        if (mismatch && !error_q) begin
          error_d    = 1'b1;
          err_addr_d = cnt_q;
        end
        if (abort_i) begin
          state_d = S_IDLE;
          cnt_d   = FIRST_A;
        end else if (last_reg) begin
          state_d = S_DONE;
          cnt_d   = FIRST_A;
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = FIRST_A;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = FIRST_A;
      end
    endcase

    // status outputs are registered from the next state
    busy_d = (state_d == S_COPY) || (state_d == S_VERIFY);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= FIRST_A;
      verify_q   <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      verify_q   <= verify_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Register-file port drive: combinational from state and counter so the
  // source read and the sgpr write/read happen in the same cycle.
  always_comb begin
    src_raddr_o = '0;
    dst_waddr_o = '0;
    dst_wdata_o = '0;
    dst_we_o    = 1'b0;
    dst_raddr_o = '0;
    case (state_q)
      S_COPY: begin
        src_raddr_o = cnt_q;
        dst_waddr_o = cnt_q;
        dst_wdata_o = src_rdata_i;
        dst_we_o    = 1'b1;
      end
      S_VERIFY: begin
        src_raddr_o = cnt_q;
        dst_raddr_o = cnt_q;
      end
      default: begin
      end
    endcase
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_sgpr_copy_ctrl.sv
`timescale 1ns/1ps
module tb_sgpr_copy_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int FR = 1;
  localparam int LR = 31;

  localparam int K_COPY = 0;
  localparam int K_VER  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic          verify_en_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, error_o, dst_we_o;
  logic [AW-1:0] err_addr_o, src_raddr_o, dst_waddr_o, dst_raddr_o;
  logic [DW-1:0] src_rdata_i, dst_wdata_o, dst_rdata_i;

  // source register file, sgpr stand-in, read-side fault mask, model copy
  logic [DW-1:0] src_mem   [32];
  logic [DW-1:0] dst_mem   [32];
  logic [DW-1:0] fault     [32];
  logic [DW-1:0] model_dst [32];

  rec_t          exp_q[$];
  logic          m_err = 1'b0;
  logic [AW-1:0] m_err_addr = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sgpr_copy_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIRST_REG(FR), .LAST_REG(LR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .verify_en_i(verify_en_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_addr_o(err_addr_o), .src_raddr_o(src_raddr_o), .src_rdata_i(src_rdata_i),
    .dst_waddr_o(dst_waddr_o), .dst_wdata_o(dst_wdata_o), .dst_we_o(dst_we_o),
    .dst_raddr_o(dst_raddr_o), .dst_rdata_i(dst_rdata_i)
  );

  assign src_rdata_i = src_mem[src_raddr_o];
  assign dst_rdata_i = dst_mem[dst_raddr_o] ^ fault[dst_raddr_o];

  always @(posedge clk) begin
    if (dst_we_o) dst_mem[dst_waddr_o] <= dst_wdata_o;
  end

  // Reference model: an accepted start expands into the list of per-cycle
  // actions (copy each register, verify each register, done); one is
  // consumed per edge. Empty list means idle.
  always @(posedge clk or negedge rst_n) begin
    rec_t h;
    rec_t t;
    if (!rst_n) begin
      exp_q.delete();
      m_err      = 1'b0;
      m_err_addr = '0;
    end else if (exp_q.size() == 0) begin
      if (start_i && !abort_i) begin
        m_err      = 1'b0;
        m_err_addr = '0;
        for (int r = FR; r <= LR; r++) begin
          t.kind = K_COPY; t.addr = AW'(r); exp_q.push_back(t);
        end
        if (verify_en_i) begin
          for (int r = FR; r <= LR; r++) begin
            t.kind = K_VER; t.addr = AW'(r); exp_q.push_back(t);
          end
        end
        t.kind = K_DONE; t.addr = '0; exp_q.push_back(t);
      end
    end else begin
      h = exp_q.pop_front();
      if (h.kind == K_COPY) begin
        model_dst[h.addr] = src_mem[h.addr];
      end else if (h.kind == K_VER) begin
        if (src_mem[h.addr] != (model_dst[h.addr] ^ fault[h.addr]) && !m_err) begin
          m_err      = 1'b1;
          m_err_addr = h.addr;
        end
      end
      if (abort_i && h.kind != K_DONE) exp_q.delete();
    end
  end

  // Cycle compare: every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic          e_busy, e_done, e_we;
    logic [AW-1:0] e_sra, e_wa, e_ra;
    logic [DW-1:0] e_wd;
    logic [55:0]   got, exp;
    e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0;
    e_sra = '0; e_wa = '0; e_ra = '0; e_wd = '0;
    if (exp_q.size() > 0) begin
      if (exp_q[0].kind == K_COPY) begin
        e_busy = 1'b1; e_we = 1'b1;
        e_sra = exp_q[0].addr; e_wa = exp_q[0].addr; e_wd = src_mem[exp_q[0].addr];
      end else if (exp_q[0].kind == K_VER) begin
        e_busy = 1'b1;
        e_sra = exp_q[0].addr; e_ra = exp_q[0].addr;
      end else begin
        e_done = 1'b1;
      end
    end
    got = {busy_o, done_o, error_o, err_addr_o, src_raddr_o, dst_waddr_o,
           dst_wdata_o, dst_we_o, dst_raddr_o};
    exp = {e_busy, e_done, m_err, m_err_addr, e_sra, e_wa, e_wd, e_we, e_ra};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle t=%0t got busy=%b done=%b err=%b ea=%0d sra=%0d wa=%0d wd=%0h we=%b ra=%0d required busy=%b done=%b err=%b ea=%0d sra=%0d wa=%0d wd=%0h we=%b ra=%0d",
               $time, busy_o, done_o, error_o, err_addr_o, src_raddr_o, dst_waddr_o,
               dst_wdata_o, dst_we_o, dst_raddr_o, e_busy, e_done, m_err, m_err_addr,
               e_sra, e_wa, e_wd, e_we, e_ra);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Run one sequence; abort_after=K asserts abort_i at edge E(K),
  // start_again=K re-pulses start_i at edge E(K+1). Negative disables.
  task automatic run_seq(input bit ver, input int abort_after, input int start_again,
                         input int limit, output int done_k, output int we_cnt,
                         output int done_cnt, output logic err_start,
                         output logic err_done, output logic [AW-1:0] ea_done);
    start_i = 1'b1; verify_en_i = ver;
    tick();
    start_i = 1'b0; verify_en_i = 1'b0;
    err_start = error_o;
    done_k = -1; we_cnt = 0; done_cnt = 0; err_done = 1'b0; ea_done = '0;
    for (int k = 0; k < limit; k++) begin
      if (dst_we_o) we_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k; err_done = error_o; ea_done = err_addr_o;
        end
      end
      abort_i = (k == abort_after - 1);
      start_i = (k == start_again);
      tick();
    end
    abort_i = 1'b0; start_i = 1'b0;
    $display("seq verify=%0d abort_after=%0d done_edge=%0d writes=%0d dones=%0d err=%0d err_addr=%0d",
             ver, abort_after, done_k, we_cnt, done_cnt, err_done, ea_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dk, wc, dc;
    logic        es, ed;
    logic [AW-1:0] ea;
    logic [55:0] outs;

    for (int i = 0; i < 32; i++) begin
      src_mem[i] = '0; fault[i] = '0;
    end

    // reset
    #1 rst_n = 1'b0;
    repeat (3) tick();
    outs = {busy_o, done_o, error_o, err_addr_o, src_raddr_o, dst_waddr_o,
            dst_wdata_o, dst_we_o, dst_raddr_o};
    check("reset_outputs", 64'(outs), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_quiet", {62'd0, busy_o, dst_we_o}, 64'd0);
    end

    // copy without verify, src[i] = 3*i
    for (int i = 0; i < 32; i++) src_mem[i] = DW'(3 * i);
    run_seq(1'b0, -1, -1, 40, dk, wc, dc, es, ed, ea);
    check("copy_done_edge", 64'(dk), 64'd31);
    check("copy_writes", 64'(wc), 64'd31);
    check("copy_done_count", 64'(dc), 64'd1);
    check("copy_busy_after", {63'd0, busy_o}, 64'd0);
    for (int i = 1; i <= 31; i++) check("readback", 64'(dst_mem[i]), 64'(3 * i));

    // copy + clean verify
    run_seq(1'b1, -1, -1, 70, dk, wc, dc, es, ed, ea);
    check("verify_done_edge", 64'(dk), 64'd62);
    check("verify_clean_err", {63'd0, ed}, 64'd0);
    check("verify_clean_addr", 64'(ea), 64'd0);

    // verify with bit 0 of regs 7 and 20 flipped on the sgpr read side
    fault[7] = 32'd1; fault[20] = 32'd1;
    run_seq(1'b1, -1, -1, 70, dk, wc, dc, es, ed, ea);
    check("fault_done_edge", 64'(dk), 64'd62);
    check("fault_err", {63'd0, ed}, 64'd1);
    check("fault_err_addr", 64'(ea), 64'd7);
    fault[7] = '0; fault[20] = '0;

    // abort at E10 of COPY; new start also clears the sticky error
    for (int i = 0; i < 32; i++) src_mem[i] = DW'(3 * i + 1000);
    run_seq(1'b0, 10, -1, 45, dk, wc, dc, es, ed, ea);
    check("start_clears_err", {63'd0, es}, 64'd0);
    check("abort_writes", 64'(wc), 64'd10);
    check("abort_no_done", 64'(dc), 64'd0);
    check("abort_reg10", 64'(dst_mem[10]), 64'd1030);
    check("abort_reg11_kept", 64'(dst_mem[11]), 64'd33);
    run_seq(1'b0, -1, -1, 40, dk, wc, dc, es, ed, ea);
    check("after_abort_done_edge", 64'(dk), 64'd31);
    check("after_abort_writes", 64'(wc), 64'd31);

    // start during COPY is ignored
    run_seq(1'b0, -1, 5, 80, dk, wc, dc, es, ed, ea);
    check("restart_ignored_dones", 64'(dc), 64'd1);
    check("restart_ignored_writes", 64'(wc), 64'd31);

    // start together with abort in IDLE
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    repeat (3) tick();
    check("start_abort_idle", {62'd0, busy_o, dst_we_o}, 64'd0);

    // reset asserted at E15
    start_i = 1'b1; verify_en_i = 1'b1;
    tick();
    start_i = 1'b0; verify_en_i = 1'b0;
    repeat (14) tick();
    check("pre_reset_busy", {63'd0, busy_o}, 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    outs = {busy_o, done_o, error_o, err_addr_o, src_raddr_o, dst_waddr_o,
            dst_wdata_o, dst_we_o, dst_raddr_o};
    check("mid_reset_outputs", 64'(outs), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 32; i++) begin
        src_mem[i] = $urandom;
        fault[i]   = ($urandom_range(0, 15) == 0) ? (DW'(1) << $urandom_range(0, DW - 1)) : '0;
      end
      for (int c = 0; c < $urandom_range(20, 90); c++) begin
        start_i     = ($urandom_range(0, 7) == 0);
        verify_en_i = $urandom_range(0, 1) == 1;
        abort_i     = ($urandom_range(0, 39) == 0);
        tick();
      end
      start_i = 1'b0; verify_en_i = 1'b0; abort_i = 1'b0;
    end
    repeat (80) tick();
    check("final_idle", {62'd0, busy_o, dst_we_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sgpr_copy_ctrl.md
# sgpr_copy_ctrl

Register-file copy/verify sequencer that sits directly upstream of `sgpr` in the fault-tolerant system. On request it reads every architectural register (x1..x31) from a source register file and drives them into the `sgpr` write port. It can then read each register back through `sgpr` read port B and compare it against the source. The controller is used to transfer state to a spare core during recovery and reports the first mismatching register.

## Interface

- `ADDR_WIDTH`, default 5: register address width.
- `DATA_WIDTH`, default 32: register data width.
- `FIRST_REG`, default 1: first register copied (x0 is hardwired and skipped).
- `LAST_REG`, default 31: last register copied.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: begin a sequence; sampled only in IDLE.
- `verify_en_i` in 1: sampled together with `start_i`; 1 adds a readback/compare pass.
- `abort_i` in 1: terminate the current sequence.
- `busy_o` out 1: high in COPY and VERIFY.
- `done_o` out 1: one-cycle pulse on normal completion.
- `error_o` out 1: sticky mismatch flag; cleared on accepted start.
- `err_addr_o` out ADDR_WIDTH: address of the first mismatch.
- `src_raddr_o` out ADDR_WIDTH: source read address; the source read is combinational.
- `src_rdata_i` in DATA_WIDTH: source read data.
- `dst_waddr_o` out ADDR_WIDTH: drives `sgpr` `waddr_a_i`.
- `dst_wdata_o` out DATA_WIDTH: drives `sgpr` `wdata_a_i`.
- `dst_we_o` out 1: drives `sgpr` `we_a_i`.
- `dst_raddr_o` out ADDR_WIDTH: drives `sgpr` `raddr_b_i`.
- `dst_rdata_i` in DATA_WIDTH: from `sgpr` `rdata_b_o`; the read is combinational.

## Operation

- States: IDLE, COPY, VERIFY, DONE. Registered state is the address counter `cnt`, which is ADDR_WIDTH wide.
- IDLE with `start_i`=1 and `abort_i`=0 at an edge:
  - go to COPY and set `cnt`=FIRST_REG;
  - latch `verify_en_i`;
  - clear `error_o` and `err_addr_o`.
- COPY is combinational from state and `cnt`:
  - `src_raddr_o`=`dst_waddr_o`=`cnt`;
  - `dst_wdata_o`=`src_rdata_i`;
  - `dst_we_o`=1.
  - One register is written per cycle and committed by `sgpr` at the next edge.
- COPY with `cnt`=LAST_REG at an edge: go to VERIFY with `cnt`=FIRST_REG if verify was latched, else go to DONE. Otherwise `cnt`+1.
- VERIFY:
  - `src_raddr_o`=`dst_raddr_o`=`cnt`, and `dst_we_o`=0.
  - At each edge, if `src_rdata_i`≠`dst_rdata_i` and `error_o`=0, set `error_o`=1 and `err_addr_o`=`cnt`.
  - Later mismatches do not overwrite `err_addr_o`, and the pass always runs to LAST_REG.
- VERIFY with `cnt`=LAST_REG at an edge: go to DONE.
- DONE: `done_o`=1 for exactly one cycle, then unconditionally go to IDLE.
- Outside COPY and VERIFY, all address and data outputs are 0 and `dst_we_o`=0.
- `abort_i`=1 at an edge in COPY or VERIFY:
  - go to IDLE with no `done_o`;
  - the write in the abort cycle still completes;
  - `error_o` and `err_addr_o` are retained.
- `abort_i` has priority over `start_i` in IDLE, so the state stays IDLE.
- `start_i` is ignored in COPY, VERIFY and DONE.
- Arithmetic: `cnt` never exceeds LAST_REG and never wraps. FIRST_REG ≤ LAST_REG < 2^ADDR_WIDTH.

## Timing

- Reset (`rst_n` low, asynchronous):
  - state goes to IDLE and `cnt` to FIRST_REG;
  - `busy_o`, `done_o`, `error_o`, `dst_we_o` = 0;
  - `err_addr_o` and all address/data outputs = 0.
- Reset asserted mid-sequence aborts immediately; a partial copy is left in `sgpr`.
- Count N = LAST_REG−FIRST_REG+1, which is 31 by default. Let `start_i` be accepted at edge E0.
  - COPY occupies the cycles after E0 through E(N).
  - Without verify, `done_o` is high in the cycle after E(N), i.e. E31 by default.
  - With verify, VERIFY occupies the cycles after E(N) through E(2N), and `done_o` is high after E(2N), i.e. E62.
- `busy_o` is registered from state: high from after E0 until the DONE state.
- Back-to-back: the earliest next start is accepted at the edge that leaves DONE + 1, i.e. in IDLE.
- The mismatch compare is sampled at the clock edge; the combinational read paths must settle within one cycle.

## Test plan

- Reset: hold `rst_n`=0 → all outputs 0. Release, and with no start → `busy_o`=0 and `dst_we_o`=0 indefinitely.
- Copy without verify: source reg i = 3·i, pulse `start_i` with `verify_en_i`=0.
  - `dst_we_o` is high 31 cycles with addresses 1..31 and data 3..93.
  - `done_o` pulses at E31; `busy_o` is low afterwards.
  - Read back through the `sgpr` A/B ports → 3·i for all i.
- Copy with verify, clean: same stimulus with `verify_en_i`=1 → `done_o` at E62, `error_o`=0, `err_addr_o`=0.
- Verify with fault: destination model flips bit 0 of regs 7 and 20 after the copy → `error_o`=1 and `err_addr_o`=7 at `done_o`.
  - A new start clears both.
- Abort: assert `abort_i` at edge E10 of COPY.
  - Regs 1..10 are written and `dst_we_o`=0 from the next cycle.
  - No `done_o` pulse; the next start runs a full sequence.
- Corner cases:
  - `start_i` pulsed during COPY is ignored: exactly one `done_o`.
  - `start_i`+`abort_i` together in IDLE → stays IDLE.
  - `rst_n` asserted at E15 → outputs 0 immediately.
